// File: rtl/two_to_one_mux_pkg.sv
// Shared datapath definitions for the 2:1 selector: default width and data type.
package two_to_one_mux_pkg;

  localparam int MUX_W_DEFAULT = 5;

  typedef logic [MUX_W_DEFAULT-1:0] data_t;

endpackage

// File: rtl/two_to_one_mux_if.sv
// Select/data bundle of the 2:1 selector; master drives sel/A/B, slave returns out.
interface two_to_one_mux_if
  import two_to_one_mux_pkg::*;
#(
  parameter int WIDTH = MUX_W_DEFAULT
);

  // No handshake: sel, A and B are consumed every cycle (or continuously in
  // combinational mode); out is always valid for the current configuration.
  logic             sel;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] out;

  modport master (
    output sel,
    output A,
    output B,
    input  out
  );

  modport slave (
    input  sel,
    input  A,
    input  B,
    output out
  );

endinterface

// File: rtl/dff_rst_n.sv
// Generic WIDTH-bit register, asynchronous active-low clear to zero, loads every cycle.
module dff_rst_n #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/two_to_one_mux.sv
// Width-parameterised 2:1 selector (sel=0 -> A, sel=1 -> B) with optional output register.
module two_to_one_mux
  import two_to_one_mux_pkg::*;
#(
  parameter int WIDTH   = MUX_W_DEFAULT,
  parameter int REG_OUT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  two_to_one_mux_if.slave    bus
);

  logic [WIDTH-1:0] mux_val;

  // An unknown select yields an all-X result rather than a bitwise merge of A and B.
  always_comb begin
    mux_val = 'x;
    case (bus.sel)
      1'b0:    mux_val = bus.A;
      1'b1:    mux_val = bus.B;
      default: mux_val = 'x;
    endcase
  end

  if (WIDTH < 1 || (REG_OUT != 0 && REG_OUT != 1)) begin : g_param_check
    $error("two_to_one_mux: WIDTH must be >= 1 and REG_OUT must be 0 or 1");
  end

  if (REG_OUT == 1) begin : g_reg_out
    dff_rst_n #(
      .WIDTH (WIDTH)
    ) u_out_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (mux_val),
      .q     (bus.out)
    );
  end else begin : g_comb_out
    // Clock and reset are deliberately ignored in this configuration.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign bus.out        = mux_val;
  end

endmodule

// File: tb/tb_two_to_one_mux.sv
// Bench for two_to_one_mux: one combinational and one registered instance against a select model.
module tb_two_to_one_mux;
  import two_to_one_mux_pkg::*;

  localparam int W = MUX_W_DEFAULT;

  logic clk;
  logic rst_n;

  two_to_one_mux_if #(.WIDTH(W)) if_c ();
  two_to_one_mux_if #(.WIDTH(W)) if_r ();

  two_to_one_mux #(.WIDTH(W), .REG_OUT(0)) dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_c.slave)
  );

  two_to_one_mux #(.WIDTH(W), .REG_OUT(1)) dut_r (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_r.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input data_t got, input data_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Reference: index a two-entry table by the select bit.
  function automatic data_t model(input logic s, input data_t a, input data_t b);
    data_t pick[2];
    pick[0] = a;
    pick[1] = b;
    return pick[s];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_c(input logic s, input data_t a, input data_t b);
    if_c.sel = s;
    if_c.A   = a;
    if_c.B   = b;
    #1;
  endtask

  task automatic drive_r(input logic s, input data_t a, input data_t b);
    if_r.sel = s;
    if_r.A   = a;
    if_r.B   = b;
  endtask

  typedef struct {
    logic  s;
    data_t a;
    data_t b;
    data_t exp;
  } vec_t;

  vec_t dir_vecs[7];

  initial begin
    data_t hold_val;
    logic  rs;
    data_t ra, rb;

    rst_n = 1'b1;
    drive_c(1'b0, '0, '0);
    drive_r(1'b0, '0, '0);

    // Combinational directed vectors
    dir_vecs[0] = '{1'b0, 5'b00000, 5'b00001, 5'b00000};
    dir_vecs[1] = '{1'b0, 5'b00010, 5'b00100, 5'b00010};
    dir_vecs[2] = '{1'b0, 5'b10000, 5'b00000, 5'b10000};
    dir_vecs[3] = '{1'b1, 5'b10000, 5'b00000, 5'b00000};
    dir_vecs[4] = '{1'b1, 5'b10000, 5'b00001, 5'b00001};
    dir_vecs[5] = '{1'b1, 5'b00010, 5'b00100, 5'b00100};
    dir_vecs[6] = '{1'b1, 5'b00010, 5'b01000, 5'b01000};
    foreach (dir_vecs[i]) begin
      drive_c(dir_vecs[i].s, dir_vecs[i].a, dir_vecs[i].b);
      check($sformatf("comb_dir%0d", i), if_c.out, dir_vecs[i].exp);
    end

    // Combinational exhaustive sweep
    for (int v = 0; v < (1 << (2 * W + 1)); v++) begin
      logic [2*W:0] vv;
      vv = (2*W+1)'(v);
      drive_c(vv[2*W], vv[2*W-1:W], vv[W-1:0]);
      check("comb_sweep", if_c.out, model(vv[2*W], vv[2*W-1:W], vv[W-1:0]));
    end

    // Unselected input must not disturb out
    for (int i = 0; i < 20; i++) begin
      rs = 1'(i % 2);
      ra = data_t'($urandom_range(0, (1 << W) - 1));
      rb = data_t'($urandom_range(0, (1 << W) - 1));
      drive_c(rs, ra, rb);
      hold_val = rs ? rb : ra;
      if (rs) drive_c(rs, ~ra, rb);
      else    drive_c(rs, ra, ~rb);
      check("comb_unselected", if_c.out, hold_val);
    end

    // Registered: first load, then asynchronous reset
    @(negedge clk);
    drive_r(1'b0, 5'b11111, 5'b00000);
    @(posedge clk); #1;
    check("reg_load", if_r.out, 5'b11111);
    #2 rst_n = 1'b0;
    #1 check("reg_rst_async", if_r.out, '0);
    repeat (2) @(posedge clk);
    #1 check("reg_rst_hold", if_r.out, '0);
    check("comb_rst_ignored", if_c.out, model(if_c.sel, if_c.A, if_c.B));

    @(negedge clk);
    rst_n = 1'b1;
    drive_r(1'b1, 5'b00000, 5'b10101);
    #1 check("reg_release_no_edge", if_r.out, '0);
    @(posedge clk); #1;
    check("reg_release", if_r.out, 5'b10101);

    // Mid-cycle change invisible until next edge
    @(negedge clk);
    drive_r(1'b0, 5'b00011, 5'b10101);
    @(posedge clk); #1;
    check("reg_pre_change", if_r.out, 5'b00011);
    #2 if_r.A = 5'b01100;
    #1 check("reg_between_edges", if_r.out, 5'b00011);
    @(posedge clk); #1;
    check("reg_after_edge", if_r.out, 5'b01100);
    #2 rst_n = 1'b0;
    #1 check("reg_rst_midcycle", if_r.out, '0);

    // Random stream with a mid-stream reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!rst_n) begin
        rst_n = 1'b1;
        #1 check("reg_no_stale", if_r.out, '0);
      end
      rs = 1'($urandom_range(0, 1));
      ra = data_t'($urandom_range(0, (1 << W) - 1));
      rb = data_t'($urandom_range(0, (1 << W) - 1));
      drive_r(rs, ra, rb);
      exp_q.push_back(model(rs, ra, rb));
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        check("reg_queue_empty", if_r.out, 'x);
      end else begin
        check($sformatf("reg_rand%0d", i), if_r.out, exp_q.pop_front());
      end
      // Inputs moving after the edge must not reach out before the next edge
      drive_r(~rs, ~ra, ~rb);
      #1 check("reg_post_edge_hold", if_r.out, model(rs, ra, rb));
      drive_r(rs, ra, rb);
      if (i == 50) begin
        #1 rst_n = 1'b0;
        #1 check("reg_rst_stream", if_r.out, '0);
      end
    end

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL reg_queue_leftover: got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
